mc_alu_sequencer: RTL and testbench
===================================

# mc_alu_sequencer

Multi-cycle control sequencer for the integer datapath. Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it into a 5-bit `ALUControl` code, which also drives the immediate extender's sign/zero selection. It then steps the instruction through EXEC, MEM and WB phases, issuing one-cycle datapath strobes in each. Sits between the instruction register and the ALU/extender/register-file/data-memory datapath.

## Interface
- No parameters; encodings are fixed below.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `instr_valid` input 1: instruction word offered.
- `instr` input 32: instruction; opcode `[31:26]`, funct `[5:0]`.
- `instr_ready` output 1: high only in IDLE.
- `alu_zero` input 1: ALU zero flag; sampled in EXEC.
- `mem_ready` input 1: data memory completes the access this cycle.
- `ALUControl` output 5: decoded ALU operation; feeds the ALU and extender.
- `alu_src_imm` output 1: ALU operand B is the extended immediate.
- `reg_dst_rd` output 1: write destination is rd (1) or rt (0).
- `mem_to_reg` output 1: writeback data is taken from memory.
- `reg_write`, `mem_read`, `mem_write` output 1 each: phase strobes.
- `branch_taken` output 1: one-cycle pulse.
- `done` output 1: one-cycle pulse when the instruction retires.
- `illegal` output 1: qualifies `done`; the instruction was not decodable.

## Operation
- ALUControl codes:
  - ADD 00000, ADDU 00001, SUB 00010, SUBU 00011
  - AND 00100, OR 00101, XOR 00110, NOR 00111
  - SLTU 01000, SLT 01001
  - SLL 01110, SLLV 01111, SRL 10000, SRLV 10001, SRA 10010, SRAV 10011
- R-type (opcode 000000): funct 20/21/22/23/24/25/26/27/2A/2B/00/04/02/06/03/07 (hex) map to ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SLLV/SRL/SRLV/SRA/SRAV. Sets `reg_dst_rd`=1, `alu_src_imm`=0. Any other funct is illegal.
- I-type opcodes (all set `alu_src_imm`=1, `reg_dst_rd`=0):
  - addi 08 -> ADD; addiu 09 -> ADDU; sltiu 0B -> SLTU.
  - lw 23 -> ADD, `mem_to_reg`=1.
  - sw 2B -> ADD.
  - beq 04 -> SUB, with `alu_src_imm`=0.
  - Any other opcode is illegal.
- FSM states: IDLE, DECODE, EXEC, MEM, WB.
  - IDLE: `instr_ready`=1. `instr_valid` & `instr_ready` latches `instr`; next state DECODE.
  - DECODE: registers `ALUControl` and the static selects. Illegal -> `done`=1, `illegal`=1 this cycle, next IDLE. Otherwise -> EXEC.
  - EXEC: ALU/R-type/addi/addiu/sltiu -> WB. lw/sw -> MEM. beq -> `branch_taken`=`alu_zero`, `done`=1, next IDLE.
  - MEM: `mem_read` (lw) or `mem_write` (sw) held high until `mem_ready`.
    - lw with `mem_ready` -> WB.
    - sw with `mem_ready` -> `done`=1, next IDLE.
    - No `mem_ready` -> stay in MEM indefinitely.
  - WB: `reg_write`=1, `done`=1, next IDLE.
- `ALUControl` and the static selects hold their values from DECODE exit until the next DECODE.
- All strobes are combinational from state and the latched decode; they are never high in IDLE.
- `instr` is ignored outside IDLE. `instr_valid` dropping mid-instruction has no effect.

## Timing
- Reset (async assert, sync to `clk` on release): state IDLE, `ALUControl`=00000. All selects, strobes, `done` and `illegal` are 0; `instr_ready`=1 in the first cycle after release.
- Handshake cycle = T. Latency to `done`, counting from T:
  - illegal: T+1
  - beq: T+2
  - ALU ops: T+3
  - sw: T+2+N
  - lw: T+3+N
  - N ≥ 1 is the number of MEM cycles up to and including the `mem_ready` cycle.
- `mem_ready` high on the first MEM cycle gives N=1.
- `mem_ready` outside MEM is ignored.
- `instr_ready` returns the cycle after `done`; back-to-back issue gives one IDLE cycle between instructions.
- Reset mid-instruction aborts immediately. No `done` or strobe is issued for the aborted instruction.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles -> `instr_ready`=1, `ALUControl`=00000, all strobes 0. Asserting reset while in MEM drops `mem_read` asynchronously.
- R-type SRA (`instr`=0x00021883) -> `ALUControl`=10010, `reg_dst_rd`=1, `reg_write` and `done` pulse at T+3.
- sltiu 0x2C22FFFF -> `ALUControl`=01000, `alu_src_imm`=1, `done` at T+3.
- lw 0x8C220004 with `mem_ready` delayed 3 cycles -> `mem_read` high 3 cycles, `reg_write`=`mem_to_reg`=1 at T+6.
- beq 0x10220003: `alu_zero`=1 gives `branch_taken`=1 and `done` at T+2; `alu_zero`=0 gives `branch_taken`=0.
- Illegal opcode 0xFC000000 -> `done`=`illegal`=1 at T+1, no strobes. Back-to-back illegal then addi 0x20220005 -> `ALUControl`=00000, `reg_write` at its T+3.

Source files
------------

// File: rtl/mc_alu_sequencer_if.sv
// mc_alu_sequencer_if: instruction handshake plus datapath control/status bundle.
// Ports carried:
//   instr_valid, instr, instr_ready     - instruction valid/ready handshake
//   alu_zero, mem_ready                 - datapath status inputs to the sequencer
//   ALUControl, alu_src_imm, reg_dst_rd, mem_to_reg - held decode selects
//   reg_write, mem_read, mem_write, branch_taken    - phase strobes
//   done, illegal                       - retire pulse and its qualifier
// master: instruction source and datapath side; slave: the sequencer.
interface mc_alu_sequencer_if;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        alu_zero;
   logic        mem_ready;
   logic [4:0]  ALUControl;
   logic        alu_src_imm;
   logic        reg_dst_rd;
   logic        mem_to_reg;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        branch_taken;
   logic        done;
   logic        illegal;
   modport master (
      output instr_valid, instr, alu_zero, mem_ready,
      input  instr_ready, ALUControl, alu_src_imm, reg_dst_rd, mem_to_reg,
             reg_write, mem_read, mem_write, branch_taken, done, illegal
   );
   modport slave (
      input  instr_valid, instr, alu_zero, mem_ready,
      output instr_ready, ALUControl, alu_src_imm, reg_dst_rd, mem_to_reg,
             reg_write, mem_read, mem_write, branch_taken, done, illegal
   );
endinterface

// File: rtl/mc_alu_sequencer.sv
// mc_alu_sequencer: multi-cycle IDLE/DECODE/EXEC/MEM/WB control sequencer.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mc_alu_sequencer_if.slave: handshake in, decode selects and strobes out
module mc_alu_sequencer (
   input logic               clk,
   input logic               rst_n,
   mc_alu_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
   state_t      state, state_nx;
   logic [5:0]  op, fn;
   logic [4:0]  dec_ctl, alu_ctl;
   logic        dec_ok, dec_imm, dec_rd, dec_lw, dec_sw, dec_beq;
   logic        src_imm, dst_rd, is_lw, is_sw, is_beq;
   logic        rw, mr, mw, br, dn, ill;
   // Only opcode and funct are needed once the word is accepted.
   always_comb begin
      dec_ctl = 5'b00000;
      dec_ok  = 1'b1;
      dec_imm = 1'b1;
      dec_rd  = 1'b0;
      dec_lw  = 1'b0;
      dec_sw  = 1'b0;
      dec_beq = 1'b0;
      if (op == 6'h00) begin
         dec_imm = 1'b0;
         dec_rd  = 1'b1;
         case (fn)
            6'h20:   dec_ctl = 5'b00000;
            6'h21:   dec_ctl = 5'b00001;
            6'h22:   dec_ctl = 5'b00010;
            6'h23:   dec_ctl = 5'b00011;
            6'h24:   dec_ctl = 5'b00100;
            6'h25:   dec_ctl = 5'b00101;
            6'h26:   dec_ctl = 5'b00110;
            6'h27:   dec_ctl = 5'b00111;
            6'h2A:   dec_ctl = 5'b01001;
            6'h2B:   dec_ctl = 5'b01000;
            6'h00:   dec_ctl = 5'b01110;
            6'h04:   dec_ctl = 5'b01111;
            6'h02:   dec_ctl = 5'b10000;
            6'h06:   dec_ctl = 5'b10001;
            6'h03:   dec_ctl = 5'b10010;
            6'h07:   dec_ctl = 5'b10011;
            default: dec_ok  = 1'b0;
         endcase
      end else begin
         case (op)
            6'h08:   dec_ctl = 5'b00000;
            6'h09:   dec_ctl = 5'b00001;
            6'h0B:   dec_ctl = 5'b01000;
            6'h23:   dec_lw  = 1'b1;
            6'h2B:   dec_sw  = 1'b1;
            6'h04: begin
               dec_ctl = 5'b00010;
               dec_imm = 1'b0;
               dec_beq = 1'b1;
            end
            default: dec_ok  = 1'b0;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op      <= '0;
         fn      <= '0;
         alu_ctl <= '0;
         src_imm <= 1'b0;
         dst_rd  <= 1'b0;
         is_lw   <= 1'b0;
         is_sw   <= 1'b0;
         is_beq  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.instr_valid) begin
            op <= bus.instr[31:26];
            fn <= bus.instr[5:0];
         end
         // Illegal words load neutral selects so nothing stale can steer the datapath.
         if (state == DECODE) begin
            alu_ctl <= dec_ok ? dec_ctl : 5'b00000;
            src_imm <= dec_ok & dec_imm;
            dst_rd  <= dec_ok & dec_rd;
            is_lw   <= dec_ok & dec_lw;
            is_sw   <= dec_ok & dec_sw;
            is_beq  <= dec_ok & dec_beq;
         end
      end
   end
   always_comb begin
      state_nx = state;
      rw       = 1'b0;
      mr       = 1'b0;
      mw       = 1'b0;
      br       = 1'b0;
      dn       = 1'b0;
      ill      = 1'b0;
      case (state)
         IDLE:   state_nx = bus.instr_valid ? DECODE : IDLE;
         DECODE: begin
            state_nx = dec_ok ? EXEC : IDLE;
            dn       = ~dec_ok;
            ill      = ~dec_ok;
         end
         EXEC: begin
            state_nx = (is_lw | is_sw) ? MEM : (is_beq ? IDLE : WB);
            br       = is_beq & bus.alu_zero;
            dn       = is_beq;
         end
         MEM: begin
            mr       = is_lw;
            mw       = is_sw;
            dn       = is_sw & bus.mem_ready;
            state_nx = bus.mem_ready ? (is_lw ? WB : IDLE) : MEM;
         end
         WB: begin
            rw       = 1'b1;
            dn       = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   assign bus.instr_ready  = (state == IDLE);
   assign bus.ALUControl   = alu_ctl;
   assign bus.alu_src_imm  = src_imm;
   assign bus.reg_dst_rd   = dst_rd;
   assign bus.mem_to_reg   = is_lw;
   assign bus.reg_write    = rw;
   assign bus.mem_read     = mr;
   assign bus.mem_write    = mw;
   assign bus.branch_taken = br;
   assign bus.done         = dn;
   assign bus.illegal      = ill;
endmodule

// File: tb/tb_mc_alu_sequencer.sv
// tb_mc_alu_sequencer: scoreboard bench for mc_alu_sequencer.
// Ports: none (top-level bench driving the interface master side).
module tb_mc_alu_sequencer;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   mc_alu_sequencer_if bus ();
   mc_alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   typedef struct packed {
      logic [4:0] ctl;
      logic       imm, rd, m2r, ill;
      logic [3:0] rw, mr, mw, br;
      logic [4:0] lat;
      logic       idle_ok;
   } res_t;
   res_t sb[$];
   res_t obs[$];
   int n_chk  = 0;
   int n_fail = 0;
   logic [8:0] flags;
   logic       strobes;
   assign flags   = {bus.alu_src_imm, bus.reg_dst_rd, bus.mem_to_reg, bus.reg_write, bus.mem_read,
                     bus.mem_write, bus.branch_taken, bus.done, bus.illegal};
   assign strobes = bus.reg_write | bus.mem_read | bus.mem_write | bus.branch_taken | bus.done | bus.illegal;
   function automatic res_t mk(input logic [4:0] ctl, input logic imm, input logic rd, input logic m2r,
                               input logic ill, input logic [3:0] rw, input logic [3:0] mr,
                               input logic [3:0] mw, input logic [3:0] br, input logic [4:0] lat);
      return '{ctl: ctl, imm: imm, rd: rd, m2r: m2r, ill: ill, rw: rw, mr: mr, mw: mw, br: br,
               lat: lat, idle_ok: 1'b1};
   endfunction
   // Issues one word from an IDLE cycle, follows it to done, then inspects the following IDLE cycle.
   task automatic run(input logic [31:0] w, input logic z, input int md);
      res_t o;
      int   cyc, mcnt;
      o            = '0;
      o.idle_ok    = bus.instr_ready;
      bus.instr    = w;
      bus.instr_valid = 1'b1;
      bus.alu_zero = z;
      cyc  = 0;
      mcnt = 0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
         bus.instr_valid = 1'b0;
         bus.instr       = $urandom;
         if (bus.mem_read | bus.mem_write) begin
            mcnt++;
            bus.mem_ready = (mcnt >= md);
         end else begin
            bus.mem_ready = 1'($urandom_range(0, 1));
         end
         #1;
         if (bus.reg_write)    o.rw += 4'd1;
         if (bus.mem_read)     o.mr += 4'd1;
         if (bus.mem_write)    o.mw += 4'd1;
         if (bus.branch_taken) o.br += 4'd1;
         if (bus.done) begin
            o.lat = 5'(cyc);
            o.ctl = bus.ALUControl;
            o.imm = bus.alu_src_imm;
            o.rd  = bus.reg_dst_rd;
            o.m2r = bus.mem_to_reg;
            o.ill = bus.illegal;
            break;
         end
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      o.idle_ok = o.idle_ok & bus.instr_ready & ~strobes;
      obs.push_back(o);
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (bus.instr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 1", bus.instr_ready);
      end
      n_chk++;
      if (bus.ALUControl !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_aluctl: got %b expected 00000", bus.ALUControl);
      end
      n_chk++;
      if (flags !== 9'h000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 000000000", flags);
      end
   endtask
   task automatic test_sra;
      res_t e, o;
      sb.push_back(mk(5'b10010, 0, 1, 0, 0, 1, 0, 0, 0, 3));
      run(32'h00021883, 1'b0, 1);
      e = sb.pop_front();
      o = obs.pop_front();
      n_chk++;
      if (o.lat !== e.lat) begin
         n_fail++;
         $display("FAIL sra_latency: got %0d expected %0d", o.lat, e.lat);
      end
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL sra_record: got %h expected %h", o, e);
      end
   endtask
   task automatic test_rtype_all;
      logic [5:0] fn_t [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07};
      logic [4:0] ctl_t [16] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                 5'b00110, 5'b00111, 5'b01001, 5'b01000, 5'b01110, 5'b01111,
                                 5'b10000, 5'b10001, 5'b10010, 5'b10011};
      res_t e, o;
      for (int i = 0; i < 16; i++) begin
         sb.push_back(mk(ctl_t[i], 0, 1, 0, 0, 1, 0, 0, 0, 3));
         run({6'h00, 5'd1, 5'd2, 5'd3, 5'd4, fn_t[i]}, 1'b1, 1);
         e = sb.pop_front();
         o = obs.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL rtype_funct_%h: got %h expected %h", fn_t[i], o, e);
         end
      end
   endtask
   task automatic test_sltiu;
      res_t e, o;
      sb.push_back(mk(5'b01000, 1, 0, 0, 0, 1, 0, 0, 0, 3));
      run(32'h2C22FFFF, 1'b0, 1);
      e = sb.pop_front();
      o = obs.pop_front();
      n_chk++;
      if (o.ctl !== e.ctl || o.imm !== e.imm) begin
         n_fail++;
         $display("FAIL sltiu_selects: got ctl=%b imm=%b expected ctl=%b imm=%b", o.ctl, o.imm, e.ctl, e.imm);
      end
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL sltiu_record: got %h expected %h", o, e);
      end
   endtask
   task automatic test_mem;
      res_t e, o;
      sb.push_back(mk(5'b00000, 1, 0, 1, 0, 1, 3, 0, 0, 6));
      run(32'h8C220004, 1'b0, 3);
      sb.push_back(mk(5'b00000, 1, 0, 1, 0, 1, 1, 0, 0, 4));
      run(32'h8C220004, 1'b0, 1);
      sb.push_back(mk(5'b00000, 1, 0, 0, 0, 0, 0, 1, 0, 3));
      run(32'hAC220004, 1'b0, 1);
      sb.push_back(mk(5'b00000, 1, 0, 0, 0, 0, 0, 2, 0, 4));
      run(32'hAC220004, 1'b0, 2);
      for (int i = 0; i < 4; i++) begin
         e = sb.pop_front();
         o = obs.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mem_access_%0d: got %h expected %h", i, o, e);
         end
      end
   endtask
   task automatic test_beq;
      res_t e, o;
      sb.push_back(mk(5'b00010, 0, 0, 0, 0, 0, 0, 0, 1, 2));
      run(32'h10220003, 1'b1, 1);
      sb.push_back(mk(5'b00010, 0, 0, 0, 0, 0, 0, 0, 0, 2));
      run(32'h10220003, 1'b0, 1);
      e = sb.pop_front();
      o = obs.pop_front();
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL beq_taken: got %h expected %h", o, e);
      end
      e = sb.pop_front();
      o = obs.pop_front();
      n_chk++;
      if (o.br !== e.br || o !== e) begin
         n_fail++;
         $display("FAIL beq_not_taken: got %h expected %h", o, e);
      end
   endtask
   // Selects seen at an illegal done still belong to the previous instruction.
   task automatic test_illegal;
      res_t e, o;
      sb.push_back(mk(5'b00001, 1, 0, 0, 0, 1, 0, 0, 0, 3));
      run(32'h24220001, 1'b0, 1);
      sb.push_back(mk(5'b00001, 1, 0, 0, 1, 0, 0, 0, 0, 1));
      run(32'h00000001, 1'b0, 1);
      sb.push_back(mk(5'b00010, 0, 0, 0, 0, 0, 0, 0, 0, 2));
      run(32'h10220003, 1'b0, 1);
      sb.push_back(mk(5'b00010, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      run(32'hFC000000, 1'b1, 1);
      for (int i = 0; i < 4; i++) begin
         e = sb.pop_front();
         o = obs.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL illegal_seq_%0d: got %h expected %h", i, o, e);
         end
      end
   endtask
   task automatic test_back_to_back;
      res_t e, o;
      sb.push_back(mk(5'b00000, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      run(32'hFC000000, 1'b0, 1);
      sb.push_back(mk(5'b00000, 1, 0, 0, 0, 1, 0, 0, 0, 3));
      run(32'h20220005, 1'b0, 1);
      e = sb.pop_front();
      o = obs.pop_front();
      n_chk++;
      if (o.lat !== e.lat || o.ill !== e.ill || o.rw !== e.rw || o.idle_ok !== e.idle_ok) begin
         n_fail++;
         $display("FAIL b2b_illegal: got lat=%0d ill=%b rw=%0d idle=%b expected lat=%0d ill=%b rw=%0d idle=%b",
                  o.lat, o.ill, o.rw, o.idle_ok, e.lat, e.ill, e.rw, e.idle_ok);
      end
      e = sb.pop_front();
      o = obs.pop_front();
      n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL b2b_addi: got %h expected %h", o, e);
      end
   endtask
   task automatic test_reset_mid_mem;
      int cyc, bad;
      bus.instr       = 32'h8C220004;
      bus.instr_valid = 1'b1;
      bus.mem_ready   = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         bus.instr_valid = 1'b0;
         #1;
         cyc++;
      end while (!bus.mem_read && cyc < 10);
      n_chk++;
      if (bus.mem_read !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_reach_mem: got mem_read=%b expected 1", bus.mem_read);
      end
      #1 rst_n = 1'b0;
      #1;
      n_chk++;
      if (bus.mem_read !== 1'b0 || bus.instr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_async: got mem_read=%b ready=%b expected 0 1", bus.mem_read, bus.instr_ready);
      end
      repeat (2) @(negedge clk);
      rst_n         = 1'b1;
      bus.mem_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (strobes || !bus.instr_ready) bad++;
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      #1;
      n_chk++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
      end
   endtask
   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.alu_zero    = 1'b0;
      bus.mem_ready   = 1'b0;
      #1;
      test_reset;
      test_sra;
      test_rtype_all;
      test_sltiu;
      test_mem;
      test_beq;
      test_illegal;
      test_back_to_back;
      test_reset_mid_mem;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
